// File: rtl/rv32i_single_cycle_cpu.sv
// Single-cycle RV32I core with internal instruction memory, data memory and register file,
// all preloaded from input images while reset is held.
module rv32i_single_cycle_cpu (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] initial_instructions    [0:31],
  input  logic [31:0] initial_register_values [0:31],
  input  logic [31:0] initial_memory_values   [0:31],
  output logic [31:0] pc_check,
  output logic [31:0] register_check          [0:31]
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] imem_q [0:31];
  logic [31:0] dmem_q [0:31];
  logic [31:0] regs_q [0:31];

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [31:0] immI;
  logic [31:0] immS;
  logic [31:0] immB;
  logic [31:0] immU;
  logic [31:0] immJ;
  logic [31:0] rs1Val;
  logic [31:0] rs2Val;
  logic [31:0] pcPlus4;

  logic [31:0] aluB;
  logic [31:0] aluResult;
  logic        branchTaken;

  logic [6:0]  memAddr;
  logic [31:0] memWord;
  logic [4:0]  laneShift;
  logic [31:0] laneData;
  logic [31:0] loadData;
  logic [31:0] storeMask;
  logic [31:0] storeData;

  logic        regWrite;
  logic [31:0] writeData;
  logic        memWrite;

  assign instr   = imem_q[pc_q[6:2]];
  assign opcode  = instr[6:0];
  assign rd      = instr[11:7];
  assign funct3  = instr[14:12];
  assign rs1     = instr[19:15];
  assign rs2     = instr[24:20];

  assign immI = {{20{instr[31]}}, instr[31:20]};
  assign immS = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign immB = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign immU = {instr[31:12], 12'b0};
  assign immJ = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // regs_q[0] is zeroed at reset and never written, so reads need no special case
  assign rs1Val  = regs_q[rs1];
  assign rs2Val  = regs_q[rs2];
  assign pcPlus4 = pc_q + 32'd4;

  assign pc_check       = pc_q;
  assign register_check = regs_q;

  // Shared ALU for OP and OP-IMM; instr[30] selects SUB (register form only) and SRA/SRAI
  always_comb begin
    aluB      = (opcode == OpReg) ? rs2Val : immI;
    aluResult = 32'd0;
    case (funct3)
      3'b000:  aluResult = ((opcode == OpReg) && instr[30]) ? rs1Val - aluB : rs1Val + aluB;
      3'b001:  aluResult = rs1Val << aluB[4:0];
      3'b010:  aluResult = ($signed(rs1Val) < $signed(aluB)) ? 32'd1 : 32'd0;
      3'b011:  aluResult = (rs1Val < aluB) ? 32'd1 : 32'd0;
      3'b100:  aluResult = rs1Val ^ aluB;
      3'b101:  aluResult = instr[30] ? 32'($signed(rs1Val) >>> aluB[4:0]) : rs1Val >> aluB[4:0];
      3'b110:  aluResult = rs1Val | aluB;
      default: aluResult = rs1Val & aluB;
    endcase
  end

  always_comb begin
    branchTaken = 1'b0;
    case (funct3)
      3'b000:  branchTaken = (rs1Val == rs2Val);
      3'b001:  branchTaken = (rs1Val != rs2Val);
      3'b100:  branchTaken = ($signed(rs1Val) < $signed(rs2Val));
      3'b101:  branchTaken = ($signed(rs1Val) >= $signed(rs2Val));
      3'b110:  branchTaken = (rs1Val < rs2Val);
      3'b111:  branchTaken = (rs1Val >= rs2Val);
      default: branchTaken = 1'b0;
    endcase
  end

  // Only the low 7 address bits reach the 32-word data memory, so the add is done at that width
  always_comb begin
    memAddr   = (opcode == OpStore) ? (rs1Val[6:0] + immS[6:0]) : (rs1Val[6:0] + immI[6:0]);
    memWord   = dmem_q[memAddr[6:2]];
    laneShift = {memAddr[1:0], 3'b000};
    laneData  = memWord >> laneShift;
    loadData  = memWord;
    storeMask = 32'hFFFF_FFFF;
    storeData = rs2Val;
    case (funct3)
      3'b000:  loadData = {{24{laneData[7]}}, laneData[7:0]};
      3'b001:  loadData = {{16{laneData[15]}}, laneData[15:0]};
      3'b100:  loadData = {24'd0, laneData[7:0]};
      3'b101:  loadData = {16'd0, laneData[15:0]};
      default: loadData = memWord;
    endcase
    case (funct3)
      3'b000: begin
        storeMask = 32'h0000_00FF << laneShift;
        storeData = rs2Val << laneShift;
      end
      3'b001: begin
        storeMask = 32'h0000_FFFF << laneShift;
        storeData = rs2Val << laneShift;
      end
      default: begin
        storeMask = 32'hFFFF_FFFF;
        storeData = rs2Val;
      end
    endcase
  end

  // Decode into write-back, store enable and next PC; anything unrecognised just advances the PC
  always_comb begin
    pc_d      = pcPlus4;
    regWrite  = 1'b0;
    writeData = 32'd0;
    memWrite  = 1'b0;
    case (opcode)
      OpLui: begin
        regWrite  = 1'b1;
        writeData = immU;
      end
      OpAuipc: begin
        regWrite  = 1'b1;
        writeData = pc_q + immU;
      end
      OpJal: begin
        regWrite  = 1'b1;
        writeData = pcPlus4;
        pc_d      = pc_q + immJ;
      end
      OpJalr: begin
        regWrite  = 1'b1;
        writeData = pcPlus4;
        pc_d      = (rs1Val + immI) & 32'hFFFF_FFFE;
      end
      OpBranch: begin
        if (branchTaken) begin
          pc_d = pc_q + immB;
        end
      end
      OpLoad: begin
        regWrite  = 1'b1;
        writeData = loadData;
      end
      OpStore: begin
        memWrite = 1'b1;
      end
      OpImm, OpReg: begin
        regWrite  = 1'b1;
        writeData = aluResult;
      end
      default: begin
        pc_d = pcPlus4;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= 32'd0;
      regs_q[0] <= 32'd0;
      for (int i = 0; i < 32; i++) begin
        imem_q[i] <= initial_instructions[i];
        dmem_q[i] <= initial_memory_values[i];
      end
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= initial_register_values[i];
      end
    end else begin
      pc_q <= pc_d;
      if (regWrite && (rd != 5'd0)) begin
        regs_q[rd] <= writeData;
      end
      if (memWrite) begin
        dmem_q[memAddr[6:2]] <= (memWord & ~storeMask) | (storeData & storeMask);
      end
    end
  end

endmodule

// File: tb/tb_rv32i_single_cycle_cpu.sv
// Directed-program bench for rv32i_single_cycle_cpu: each scenario loads images, resets,
// runs a fixed number of edges and compares PC/registers against hand-computed values.
module tb_rv32i_single_cycle_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] initInstr [0:31];
  logic [31:0] initRegs  [0:31];
  logic [31:0] initMem   [0:31];
  logic [31:0] pcCheck;
  logic [31:0] regCheck  [0:31];

  int checkCount = 0;
  int errorCount = 0;

  rv32i_single_cycle_cpu dut (
    .clk                     (clk),
    .reset                   (reset),
    .initial_instructions    (initInstr),
    .initial_register_values (initRegs),
    .initial_memory_values   (initMem),
    .pc_check                (pcCheck),
    .register_check          (regCheck)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Unused instruction slots hold NOPs so stray fetches do nothing
  task automatic clearImages();
    for (int i = 0; i < 32; i++) begin
      initInstr[i] = 32'h0000_0013;
      initRegs[i]  = 32'd0;
      initMem[i]   = 32'd0;
    end
  endtask

  task automatic applyReset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input int edges);
    repeat (edges) @(negedge clk);
  endtask

  task automatic loadFibonacci();
    clearImages();
    initInstr[0] = 32'h00c75c63;
    initInstr[1] = 32'h00b506b3;
    initInstr[2] = 32'h00058513;
    initInstr[3] = 32'h00068593;
    initInstr[4] = 32'hfff60613;
    initInstr[5] = 32'hfedff06f;
    initInstr[6] = 32'h00068593;
    initRegs[10] = 32'd0;
    initRegs[11] = 32'd1;
    initRegs[12] = 32'd10;
    initRegs[14] = 32'd1;
  endtask

  initial begin
    // Load-immediate prologue, with preloads that the program must overwrite
    clearImages();
    initInstr[0] = 32'h00000513;
    initInstr[1] = 32'h00100593;
    initInstr[2] = 32'h00a00613;
    initInstr[3] = 32'h00100713;
    initRegs[5]  = 32'hDEAD_BEEF;
    initRegs[10] = 32'h1234_5678;
    applyReset();
    checkOutput("reset_pc", pcCheck, 32'd0);
    checkOutput("reset_x5", regCheck[5], 32'hDEAD_BEEF);
    checkOutput("reset_x10", regCheck[10], 32'h1234_5678);
    checkOutput("reset_x0", regCheck[0], 32'd0);
    applyStimulus(4);
    checkOutput("li_x10", regCheck[10], 32'd0);
    checkOutput("li_x11", regCheck[11], 32'd1);
    checkOutput("li_x12", regCheck[12], 32'd10);
    checkOutput("li_x14", regCheck[14], 32'd1);
    checkOutput("li_pc", pcCheck, 32'd16);

    loadFibonacci();
    applyReset();
    applyStimulus(6);
    checkOutput("fib_pass1_x12", regCheck[12], 32'd9);
    checkOutput("fib_pass1_pc", pcCheck, 32'd0);
    applyStimulus(6);
    checkOutput("fib_pass2_x12", regCheck[12], 32'd8);
    checkOutput("fib_pass2_x11", regCheck[11], 32'd2);
    applyStimulus(44);
    checkOutput("fib_end_x11", regCheck[11], 32'd55);
    checkOutput("fib_end_x12", regCheck[12], 32'd1);
    checkOutput("fib_end_x10", regCheck[10], 32'd34);
    checkOutput("fib_end_pc", pcCheck, 32'd28);

    // Mid-loop reset restores the preload image and PC
    loadFibonacci();
    applyReset();
    applyStimulus(20);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_pc", pcCheck, 32'd0);
    checkOutput("midreset_x12", regCheck[12], 32'd10);
    checkOutput("midreset_x11", regCheck[11], 32'd1);
    checkOutput("midreset_x13", regCheck[13], 32'd0);
    reset = 1'b0;

    // Signed vs unsigned branches on x1=-1, x2=1
    clearImages();
    initInstr[0] = 32'h0020C463;
    initInstr[2] = 32'h0020E463;
    initInstr[3] = 32'h0020D463;
    initInstr[4] = 32'h0020F463;
    initInstr[6] = 32'h00209463;
    initInstr[8] = 32'h00208463;
    initRegs[1]  = 32'hFFFF_FFFF;
    initRegs[2]  = 32'd1;
    applyReset();
    applyStimulus(1);
    checkOutput("blt_taken_pc", pcCheck, 32'd8);
    applyStimulus(1);
    checkOutput("bltu_not_pc", pcCheck, 32'd12);
    applyStimulus(1);
    checkOutput("bge_not_pc", pcCheck, 32'd16);
    applyStimulus(1);
    checkOutput("bgeu_taken_pc", pcCheck, 32'd24);
    applyStimulus(1);
    checkOutput("bne_taken_pc", pcCheck, 32'd32);
    applyStimulus(1);
    checkOutput("beq_not_pc", pcCheck, 32'd36);

    // jal ra,+8 ; jalr x0,0(x1) ; jalr x5,13(x1) clears bit 0 of the target
    clearImages();
    initInstr[0] = 32'h008000EF;
    initInstr[1] = 32'h00D082E7;
    initInstr[2] = 32'h00008067;
    applyReset();
    applyStimulus(1);
    checkOutput("jal_x1", regCheck[1], 32'd4);
    checkOutput("jal_pc", pcCheck, 32'd8);
    applyStimulus(1);
    checkOutput("jalr_ret_pc", pcCheck, 32'd4);
    applyStimulus(1);
    checkOutput("jalr_odd_pc", pcCheck, 32'd16);
    checkOutput("jalr_x5", regCheck[5], 32'd8);

    // Loads of every width, byte store, word store, read back through lw
    clearImages();
    initInstr[0] = 32'h00402183;
    initInstr[1] = 32'h00700203;
    initInstr[2] = 32'h00704283;
    initInstr[3] = 32'h006002A3;
    initInstr[4] = 32'h00402383;
    initInstr[5] = 32'h00601403;
    initInstr[6] = 32'h00605483;
    initInstr[7] = 32'h00602623;
    initInstr[8] = 32'h00C02503;
    initMem[1]   = 32'h80FF_1234;
    initMem[3]   = 32'h5555_5555;
    initRegs[6]  = 32'h1234_56AA;
    applyReset();
    applyStimulus(9);
    checkOutput("lw_x3", regCheck[3], 32'h80FF_1234);
    checkOutput("lb_x4", regCheck[4], 32'hFFFF_FF80);
    checkOutput("lbu_x5", regCheck[5], 32'h0000_0080);
    checkOutput("sb_readback_x7", regCheck[7], 32'h80FF_AA34);
    checkOutput("lh_x8", regCheck[8], 32'hFFFF_80FF);
    checkOutput("lhu_x9", regCheck[9], 32'h0000_80FF);
    checkOutput("sw_readback_x10", regCheck[10], 32'h1234_56AA);

    // x0 write, ALU mix, LUI/AUIPC and ECALL as a plain PC advance
    clearImages();
    initInstr[0] = 32'h00500013;
    initInstr[1] = 32'h00700413;
    initInstr[2] = 32'h401101B3;
    initInstr[3] = 32'h4020D213;
    initInstr[4] = 32'h001132B3;
    initInstr[5] = 32'hABCDE337;
    initInstr[6] = 32'h00001397;
    initInstr[7] = 32'h00000073;
    initRegs[1]  = 32'hFFFF_FFF0;
    initRegs[2]  = 32'd5;
    applyReset();
    applyStimulus(8);
    checkOutput("x0_stays_zero", regCheck[0], 32'd0);
    checkOutput("x0_read_x8", regCheck[8], 32'd7);
    checkOutput("sub_x3", regCheck[3], 32'd21);
    checkOutput("srai_x4", regCheck[4], 32'hFFFF_FFFC);
    checkOutput("sltu_x5", regCheck[5], 32'd1);
    checkOutput("lui_x6", regCheck[6], 32'hABCD_E000);
    checkOutput("auipc_x7", regCheck[7], 32'h0000_1018);
    checkOutput("ecall_pc", pcCheck, 32'd32);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
